stack_link_master: RTL and testbench
====================================

STACK_LINK_MASTER -- requirements
Module: stack_link_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, max cycles waiting for device ack (range 1..255).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ena  input  1  high = new requests may be accepted.
REQ-005 req_valid  input  1  host request present.
REQ-006 req_ready  output  1  master can accept a request.
REQ-007 req_op  input  2  00 NOP, 01 PUSH, 10 POP, 11 PEEK.
REQ-008 req_data  input  8  PUSH operand.
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  host consumes response.
REQ-011 rsp_data  output  8  POP/PEEK result; 0 for NOP/PUSH/error.
REQ-012 rsp_err  output  1  request rejected or timed out.
REQ-013 dev_data_o  output  8  operand to stack device ui_in.
REQ-014 dev_cmd_o  output  2  opcode to device uio_in[1:0].
REQ-015 dev_strb_o  output  1  command strobe to device uio_in[2].
REQ-016 dev_data_i  input  8  device uo_out data.
REQ-017 dev_ack_i, dev_full_i, dev_empty_i  input  1 each  device uio_out[2], [3], [4].
REQ-018 txn_count_o  output  8  count of successfully acked PUSH/POP/PEEK.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, DONE; req_ready = (state==IDLE) & ena.
REQ-020 IDLE: on req_valid & req_ready latch op/data; NOP -> DONE (err 0, data 0, no strobe).
REQ-021 IDLE precheck, same cycle: PUSH with dev_full_i=1, or POP/PEEK with dev_empty_i=1 -> DONE with rsp_err=1, no strobe.
REQ-022 Otherwise IDLE -> ISSUE; dev_strb_o=1 in ISSUE and WAIT, dev_cmd_o/dev_data_o held constant from ISSUE until leaving WAIT.
REQ-023 ISSUE -> WAIT unconditionally after one cycle; dev_ack_i in ISSUE ignored.
REQ-024 WAIT: on dev_ack_i=1 capture dev_data_i (POP/PEEK) or 0 (PUSH) into rsp_data, rsp_err=0, increment txn_count_o, -> DONE.
REQ-025 dev_strb_o, dev_cmd_o, dev_data_o return to 0 in the cycle after leaving WAIT.
REQ-026 DONE: rsp_valid=1, rsp_data/rsp_err stable until rsp_valid & rsp_ready; then -> IDLE.
REQ-027 Latency: accept at cycle N -> strobe high N+1; ack at cycle M -> rsp_valid high M+1.
REQ-028 txn_count_o wraps 255 -> 0; errors and NOPs do not count.
REQ-029 ena low mid-transaction does not abort; it only blocks acceptance in IDLE.
REQ-030 rsp_ready while not in DONE ignored; back-to-back request accepted no earlier than cycle after response handshake.

Reset
REQ-031 rst_n low asynchronously forces IDLE; all outputs 0 (req_ready 0 while rst_n low), txn_count_o 0, timeout counter 0.
REQ-032 Reset mid-transaction drops dev_strb_o immediately; no response issued for the aborted request.

Configuration
REQ-033 Macro STACK_LINK_MASTER_TIMEOUT_EN defined: counter runs in WAIT; after TIMEOUT_CYCLES WAIT cycles without ack -> DONE with rsp_err=1, rsp_data=0, no count increment.
REQ-034 Macro undefined: no timeout counter; WAIT persists until ack or reset; TIMEOUT_CYCLES unused.

Verification
REQ-035 PUSH 0xA5, empty=0 full=0, ack 2 cycles after strobe -> dev_cmd_o=01, dev_data_o=A5 held; rsp_valid, err 0, data 00; txn_count_o=1.
REQ-036 POP with device returning 0x3C on ack -> rsp_data=3C, err 0; rsp_ready held low 3 cycles -> rsp_valid/data stable all 3.
REQ-037 POP with dev_empty_i=1 -> no strobe ever, rsp_valid next cycle, rsp_err=1, txn_count_o unchanged.
REQ-038 With TIMEOUT_EN, TIMEOUT_CYCLES=4, PEEK with no ack -> rsp_err=1 after 4 WAIT cycles, strobe low next cycle; without macro strobe stays high 50 cycles.
REQ-039 256 acked PUSHes -> txn_count_o returns to 0; rst_n low during WAIT -> strobe 0 asynchronously, no rsp_valid.

Source files
------------

// File: rtl/stack_link_master.sv
// Host-side link master driving a stack device over a strobe/ack command port.
// Define STACK_LINK_MASTER_TIMEOUT_EN to abort unanswered commands after TIMEOUT_CYCLES.
module stack_link_master #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [7:0] dev_data_o,
    output logic [1:0] dev_cmd_o,
    output logic       dev_strb_o,
    input  logic [7:0] dev_data_i,
    input  logic       dev_ack_i,
    input  logic       dev_full_i,
    input  logic       dev_empty_i,
    output logic [7:0] txn_count_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;

    state_t     r_state, w_state_nx;
    logic [1:0] r_op, w_op_nx;
    logic [7:0] r_data, w_data_nx;
    logic [7:0] r_rsp_data, w_rsp_data_nx;
    logic       r_rsp_err, w_rsp_err_nx;
    logic [7:0] r_cnt, w_cnt_nx;
    logic       w_accept;
    logic       w_reject;

`ifdef STACK_LINK_MASTER_TIMEOUT_EN
    logic [7:0] r_tmo, w_tmo_nx;
`else
    logic       w_unused_tmo;
    assign w_unused_tmo = |8'(TIMEOUT_CYCLES);
`endif

    assign req_ready = rst_n & ena & (r_state == IDLE);
    assign w_accept  = req_valid & req_ready;
    // Refuse commands the device would not be able to honour
    assign w_reject  = ((req_op == OP_PUSH) & dev_full_i) |
                       ((req_op[1] == 1'b1) & dev_empty_i);

    always_comb begin
        w_state_nx    = r_state;
        w_op_nx       = r_op;
        w_data_nx     = r_data;
        w_rsp_data_nx = r_rsp_data;
        w_rsp_err_nx  = r_rsp_err;
        w_cnt_nx      = r_cnt;
`ifdef STACK_LINK_MASTER_TIMEOUT_EN
        w_tmo_nx      = '0;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_op_nx       = req_op;
                    w_data_nx     = req_data;
                    w_rsp_data_nx = '0;
                    w_rsp_err_nx  = 1'b0;
                    if (req_op == OP_NOP) begin
                        w_state_nx = DONE;
                    end else if (w_reject) begin
                        w_state_nx   = DONE;
                        w_rsp_err_nx = 1'b1;
                    end else begin
                        w_state_nx = ISSUE;
                    end
                end
            end
            ISSUE: w_state_nx = WAIT;
            WAIT: begin
                if (dev_ack_i) begin
                    w_state_nx    = DONE;
                    w_rsp_data_nx = (r_op == OP_PUSH) ? 8'h00 : dev_data_i;
                    w_rsp_err_nx  = 1'b0;
                    w_cnt_nx      = r_cnt + 8'd1;
                end
`ifdef STACK_LINK_MASTER_TIMEOUT_EN
                else if (r_tmo == 8'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nx    = DONE;
                    w_rsp_data_nx = '0;
                    w_rsp_err_nx  = 1'b1;
                end else begin
                    w_tmo_nx = r_tmo + 8'd1;
                end
`endif
            end
            DONE: begin
                if (rsp_ready) begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_data     <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_cnt      <= '0;
`ifdef STACK_LINK_MASTER_TIMEOUT_EN
            r_tmo      <= '0;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_op       <= w_op_nx;
            r_data     <= w_data_nx;
            r_rsp_data <= w_rsp_data_nx;
            r_rsp_err  <= w_rsp_err_nx;
            r_cnt      <= w_cnt_nx;
`ifdef STACK_LINK_MASTER_TIMEOUT_EN
            r_tmo      <= w_tmo_nx;
`endif
        end
    end

    // Command lines are only live while the strobe is up
    assign dev_strb_o  = (r_state == ISSUE) | (r_state == WAIT);
    assign dev_cmd_o   = dev_strb_o ? r_op : 2'b00;
    assign dev_data_o  = dev_strb_o ? r_data : 8'h00;
    assign rsp_valid   = (r_state == DONE);
    assign rsp_data    = rsp_valid ? r_rsp_data : 8'h00;
    assign rsp_err     = rsp_valid & r_rsp_err;
    assign txn_count_o = r_cnt;

endmodule

// File: tb/tb_stack_link_master.sv
// Scoreboard bench for stack_link_master: expected responses queued at issue,
// popped on the response handshake.
module tb_stack_link_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [7:0] dev_data_o;
    logic [1:0] dev_cmd_o;
    logic       dev_strb_o;
    logic [7:0] dev_data_i;
    logic       dev_ack_i;
    logic       dev_full_i;
    logic       dev_empty_i;
    logic [7:0] txn_count_o;

    int         n_chk = 0;
    int         n_err = 0;
    logic [8:0] exp_q[$];
    logic [7:0] exp_cnt = 8'd0;

    stack_link_master #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .dev_data_o (dev_data_o),
        .dev_cmd_o  (dev_cmd_o),
        .dev_strb_o (dev_strb_o),
        .dev_data_i (dev_data_i),
        .dev_ack_i  (dev_ack_i),
        .dev_full_i (dev_full_i),
        .dev_empty_i(dev_empty_i),
        .txn_count_o(txn_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] d,
                         input logic err, input logic [7:0] rd);
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        exp_q.push_back({err, rd});
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_data  = 8'h00;
    endtask

    task automatic ack_after(input int n, input logic [7:0] d);
        repeat (n) @(negedge clk);
        dev_ack_i  = 1'b1;
        dev_data_i = d;
        @(negedge clk);
        dev_ack_i  = 1'b0;
        dev_data_i = 8'h00;
    endtask

    task automatic collect(input int hold);
        int n;
        logic [8:0] e;
        n = 0;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("strb_after", 32'(dev_strb_o), 32'd0);
        check("cmd_after", 32'(dev_cmd_o), 32'd0);
        check("txn_count", 32'(txn_count_o), 32'(exp_cnt));
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp", 32'({rsp_err, rsp_data}), 32'(e));
        end
        rsp_ready = 1'b1;
        check("rsp", 32'({rsp_err, rsp_data}), 32'(e));
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    task automatic reset_in_wait();
        issue(2'b01, 8'h5A, 1'b0, 8'h00);
        @(negedge clk);
        check("rst_pre_strb", 32'(dev_strb_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_strb", 32'(dev_strb_o), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_txn", 32'(txn_count_o), 32'd0);
        exp_q.delete();
        exp_cnt = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit all_high;
        rst_n       = 1'b0;
        ena         = 1'b1;
        req_valid   = 1'b0;
        req_op      = 2'b00;
        req_data    = 8'h00;
        rsp_ready   = 1'b0;
        dev_data_i  = 8'h00;
        dev_ack_i   = 1'b0;
        dev_full_i  = 1'b0;
        dev_empty_i = 1'b0;
        #12;
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_valid", 32'(rsp_valid), 32'd0);
        check("reset_strb", 32'(dev_strb_o), 32'd0);
        check("reset_txn", 32'(txn_count_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(2'b01, 8'hA5, 1'b0, 8'h00);
        check("push_strb", 32'(dev_strb_o), 32'd1);
        check("push_cmd", 32'(dev_cmd_o), 32'd1);
        check("push_data", 32'(dev_data_o), 32'hA5);
        @(negedge clk);
        check("push_cmd_hold", 32'(dev_cmd_o), 32'd1);
        check("push_data_hold", 32'(dev_data_o), 32'hA5);
        exp_cnt++;
        ack_after(1, 8'hEE);
        collect(0);

        issue(2'b10, 8'h00, 1'b0, 8'h3C);
        ena = 1'b0;
        ack_after(1, 8'h3C);
        exp_cnt++;
        collect(3);
        ena = 1'b1;

        dev_empty_i = 1'b1;
        issue(2'b10, 8'h00, 1'b1, 8'h00);
        check("empty_strb", 32'(dev_strb_o), 32'd0);
        check("empty_fast", 32'(rsp_valid), 32'd1);
        collect(0);
        dev_empty_i = 1'b0;

        dev_full_i = 1'b1;
        issue(2'b01, 8'h42, 1'b1, 8'h00);
        check("full_strb", 32'(dev_strb_o), 32'd0);
        collect(0);
        dev_full_i = 1'b0;

        issue(2'b00, 8'h99, 1'b0, 8'h00);
        check("nop_strb", 32'(dev_strb_o), 32'd0);
        collect(0);

        issue(2'b11, 8'h00, 1'b0, 8'h77);
        dev_ack_i  = 1'b1;
        dev_data_i = 8'h11;
        @(negedge clk);
        dev_ack_i  = 1'b0;
        dev_data_i = 8'h00;
        @(negedge clk);
        check("issue_ack_ignored", 32'(rsp_valid), 32'd0);
        check("peek_cmd", 32'(dev_cmd_o), 32'd3);
        ack_after(0, 8'h77);
        exp_cnt++;
        collect(1);

        @(negedge clk);
        ena       = 1'b0;
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_data  = 8'h5C;
        repeat (3) begin
            @(negedge clk);
            check("ena_block_ready", 32'(req_ready), 32'd0);
            check("ena_block_strb", 32'(dev_strb_o), 32'd0);
        end
        ena = 1'b1;
        exp_q.push_back({1'b0, 8'h00});
        @(negedge clk);
        req_valid = 1'b0;
        check("ena_go_strb", 32'(dev_strb_o), 32'd1);
        check("ena_go_data", 32'(dev_data_o), 32'h5C);
        ack_after(1, 8'h00);
        exp_cnt++;
        collect(0);

`ifdef STACK_LINK_MASTER_TIMEOUT_EN
        issue(2'b11, 8'h00, 1'b1, 8'h00);
        repeat (4) @(negedge clk);
        check("tmo_strb_w4", 32'(dev_strb_o), 32'd1);
        check("tmo_not_yet", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("tmo_strb_drop", 32'(dev_strb_o), 32'd0);
        collect(0);
`else
        issue(2'b11, 8'h00, 1'b0, 8'h00);
        all_high = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (!dev_strb_o || rsp_valid) all_high = 1'b0;
        end
        check("no_tmo_strb_50", 32'(all_high), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("no_tmo_rst_strb", 32'(dev_strb_o), 32'd0);
        exp_q.delete();
        exp_cnt = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        reset_in_wait();

        for (int i = 0; i < 256; i++) begin
            issue(2'b01, 8'(i), 1'b0, 8'h00);
            exp_cnt++;
            ack_after(1, 8'h00);
            collect(0);
            if (i == 254) check("cnt_255", 32'(txn_count_o), 32'd255);
        end
        check("cnt_wrap", 32'(txn_count_o), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
